// File: rtl/mul32_seq_ctrl.sv
// Sequential 32x32 -> 64 multiply controller driving an external pipelined 8x8 multiplier.
// Sixteen byte-pair products are issued, realigned through a tag delay line, and summed.
module mul32_seq_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        clear,
    output logic        mul_en,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  k_reg;
    logic [31:0] a_reg, b_reg;
    logic [63:0] acc_reg;
    logic        accept, issue_push, dl_out_valid, dl_out_last;
    logic [2:0]  issue_tag;
    logic [63:0] addend;

    logic        dl_valid_reg [MUL_LAT];
    logic        dl_last_reg  [MUL_LAT];
    logic [2:0]  dl_tag_reg   [MUL_LAT];

    assign accept     = (state_reg == IDLE) && in_valid && !clear;
    assign issue_push = (state_reg == ISSUE) && !clear;
    assign issue_tag  = {1'b0, k_reg[1:0]} + {1'b0, k_reg[3:2]};

    // Tag delay line: each stage mirrors one pipeline stage of the external multiplier.
    generate
        for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_dl
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        dl_valid_reg[gi] <= 1'b0;
                        dl_last_reg[gi]  <= 1'b0;
                        dl_tag_reg[gi]   <= 3'd0;
                    end else begin
                        dl_valid_reg[gi] <= issue_push;
                        dl_last_reg[gi]  <= issue_push && (k_reg == 4'd15);
                        dl_tag_reg[gi]   <= issue_tag;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        dl_valid_reg[gi] <= 1'b0;
                        dl_last_reg[gi]  <= 1'b0;
                        dl_tag_reg[gi]   <= 3'd0;
                    end else begin
                        dl_valid_reg[gi] <= dl_valid_reg[gi-1] && !clear;
                        dl_last_reg[gi]  <= dl_last_reg[gi-1] && !clear;
                        dl_tag_reg[gi]   <= dl_tag_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign dl_out_valid = dl_valid_reg[MUL_LAT-1] && !clear;
    assign dl_out_last  = dl_last_reg[MUL_LAT-1];
    assign addend       = {48'd0, mul_out} << {dl_tag_reg[MUL_LAT-1], 3'b000};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            k_reg     <= 4'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            acc_reg   <= 64'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg   <= op_a;
                b_reg   <= op_b;
                k_reg   <= 4'd0;
                acc_reg <= 64'd0;
            end else begin
                if (issue_push && (k_reg != 4'd15))
                    k_reg <= k_reg + 4'd1;
                if (dl_out_valid)
                    acc_reg <= acc_reg + addend;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (accept) state_next = ISSUE;
            ISSUE: begin
                if (clear)                 state_next = IDLE;
                else if (k_reg == 4'd15)   state_next = DRAIN;
            end
            DRAIN: begin
                if (clear)                             state_next = IDLE;
                else if (dl_out_valid && dl_out_last)  state_next = DONE;
            end
            DONE:  if (clear || out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign mul_en    = (state_reg == ISSUE);
    assign out_valid = (state_reg == DONE);
    assign product   = acc_reg;
    assign mul_a     = mul_en ? a_reg[{k_reg[1:0], 3'b000} +: 8] : 8'd0;
    assign mul_b     = mul_en ? b_reg[{k_reg[3:2], 3'b000} +: 8] : 8'd0;

endmodule

// File: doc/mul32_seq_ctrl.md
MUL32_SEQ_CTRL -- requirements
Module: mul32_seq_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, meaning the fixed latency in cycles of the external 8x8 multiplier (legal range 1..4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  controller can accept operands.
REQ-006 op_a  input  32  unsigned multiplicand.
REQ-007 op_b  input  32  unsigned multiplier.
REQ-008 clear  input  1  synchronous abort of the current operation.
REQ-009 mul_en  output  1  a byte pair is issued to the multiplier this cycle.
REQ-010 mul_a  output  8  multiplicand byte to the multiplier.
REQ-011 mul_b  output  8  multiplier byte to the multiplier.
REQ-012 mul_out  input  16  multiplier result, valid MUL_LAT cycles after the matching mul_en.
REQ-013 out_valid  output  1  product available.
REQ-014 out_ready  input  1  consumer accepts the product.
REQ-015 product  output  64  accumulated 64-bit result.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-018 IDLE: in_ready=1; on in_valid&&!clear, capture op_a/op_b, zero the accumulator, zero the issue counter k, go to ISSUE.
REQ-019 ISSUE: mul_en=1 for exactly 16 consecutive cycles, k=0..15; mul_a=op_a byte (k mod 4); mul_b=op_b byte (k div 4).
REQ-020 At k=15 the FSM SHALL go to DRAIN; k SHALL NOT wrap and restart within one operation.
REQ-021 Each issue SHALL push a 1-bit valid plus a 3-bit shift tag (k mod 4)+(k div 4) into a MUL_LAT-deep delay line aligned with mul_out.
REQ-022 When the delay-line output is valid, the accumulator SHALL add zero-extended mul_out << (8*tag), modulo 2^64 (no overflow can occur for 32x32).
REQ-023 DRAIN SHALL last until the last tagged result is accumulated, then go to DONE on that same edge.
REQ-024 out_valid SHALL rise exactly 16+MUL_LAT rising edges after the accepting edge (18 for the default), and product SHALL equal op_a*op_b.
REQ-025 DONE: out_valid=1 with product held stable until out_ready=1; on that edge the FSM goes to IDLE and out_valid drops.
REQ-026 out_ready low SHALL stall indefinitely in DONE with no change to product.
REQ-027 in_valid while busy SHALL be ignored (in_ready=0) and SHALL NOT disturb captured operands.
REQ-028 clear in ISSUE, DRAIN or DONE SHALL return to IDLE next edge, flush the delay line, and suppress out_valid.
REQ-029 clear and in_valid together in IDLE: clear SHALL win and no operand SHALL be accepted.
REQ-030 After DONE->IDLE, a new operand SHALL be acceptable on the immediately following cycle.
REQ-031 mul_a/mul_b SHALL be 0 whenever mul_en=0.
REQ-032 product SHALL retain its last value in IDLE until the next accept zeroes it.

Reset
REQ-033 With reset=0: state=IDLE; k, accumulator, product and delay line =0; mul_en, out_valid, busy =0; in_ready=1 once reset deasserts.
REQ-034 Reset asserted mid-operation SHALL immediately abandon the operation, and no out_valid SHALL follow.

Verification
REQ-035 A=0x12345678, B=0x9ABCDEF0, out_ready=1 -> out_valid at edge 18, product=0x0B00EA4E242D2080, mul_en high for 16 cycles.
REQ-036 A=B=0xFFFFFFFF -> product=0xFFFFFFFE00000001; A=0, B=0xDEADBEEF -> product=0.
REQ-037 out_ready held low 10 cycles after out_valid -> product and out_valid stable for all 10 cycles; accept on release; in_ready=1 next cycle.
REQ-038 clear pulsed at issue k=7 -> IDLE next edge, no out_valid; a following op 0x3x0x5 -> product=0xF.
REQ-039 reset asserted during DRAIN -> all outputs at reset values immediately, no out_valid; in_valid during busy ignored.
REQ-040 Repeat REQ-035 with MUL_LAT=1 and MUL_LAT=4 -> out_valid at edges 17 and 20, same product.
